// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between instruction fetch and data access.
// MEM_ARB_RR_EN defined: round-robin on ties; undefined: data has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_owner
);

`ifndef MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Pick the owner of the next transaction from the pending requests.
  always_comb begin
    gnt_valid = i_req | d_req;
    gnt_owner = OWN_D;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      gnt_owner = ~last_grant;
`else
      gnt_owner = OWN_D;
`endif
    end else if (i_req) begin
      gnt_owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// One sequenced memory port shared by instruction fetch and data load/store.
// IDLE -> ACCESS (strobe WAIT_STATES+1 cycles) -> DONE (one-cycle ack) -> IDLE.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration in mem_arb_pick.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_oe,
  output logic              mem_w,
  output logic              busy,
  output logic              owner
);

  state_t            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              mem_oe_q, mem_oe_d;
  logic              mem_w_q, mem_w_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic gnt_valid;
  logic gnt_owner;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  // Next-state logic. Strobes, busy and acks are registered, so each is set
  // on the edge that enters the state it belongs to and cleared on the edge
  // that leaves it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    owner_d      = owner_q;
    busy_d       = busy_q;
    mem_oe_d     = mem_oe_q;
    mem_w_d      = mem_w_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_owner;
          if (gnt_owner == OWN_D) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            we_d        = d_we;
          end else begin
            mem_addr_d  = i_addr;
            we_d        = 1'b0;
          end
          cnt_d    = cnt_t'(WAIT_STATES);
          busy_d   = 1'b1;
          mem_oe_d = ~we_d;
          mem_w_d  = we_d;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          mem_oe_d = 1'b0;
          mem_w_d  = 1'b0;
          if (owner_q == OWN_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      DONE: begin
        last_grant_d = owner_q;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        mem_oe_d = 1'b0;
        mem_w_d  = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= OWN_D;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      mem_oe_q     <= 1'b0;
      mem_w_q      <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      mem_oe_q     <= mem_oe_d;
      mem_w_q      <= mem_w_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_oe    = mem_oe_q;
  assign mem_w     = mem_w_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (WAIT_STATES=1 main instance plus a
// WAIT_STATES=0 instance for the back-to-back fetch case).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned WS = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_ack, d_ack, mem_oe, mem_w, busy, owner;

  logic          z_i_req;
  logic [AW-1:0] z_i_addr, z_mem_addr;
  logic [DW-1:0] z_i_rdata, z_mem_rdata;
  logic          z_i_ack, z_mem_oe;
  logic          unused_z_d_ack, unused_z_mem_w, unused_z_busy, unused_z_owner;
  logic [DW-1:0] unused_z_d_rdata, unused_z_mem_wdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_oe(mem_oe), .mem_w(mem_w), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .i_req(z_i_req), .i_addr(z_i_addr), .i_rdata(z_i_rdata), .i_ack(z_i_ack),
    .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
    .d_rdata(unused_z_d_rdata), .d_ack(unused_z_d_ack),
    .mem_addr(z_mem_addr), .mem_wdata(unused_z_mem_wdata), .mem_rdata(z_mem_rdata),
    .mem_oe(z_mem_oe), .mem_w(unused_z_mem_w), .busy(unused_z_busy), .owner(unused_z_owner)
  );

  // Behavioural memories: the one the DUT talks to, and the reference copy.
  logic [DW-1:0] mem_arr [256];
  logic [DW-1:0] ref_mem [256];
  assign mem_rdata   = mem_arr[mem_addr];
  assign z_mem_rdata = {8'hC3, z_mem_addr};
  always @(posedge clk) if (mem_w) mem_arr[mem_addr] <= mem_wdata;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction order and expected read data.
  typedef struct {
    logic          own;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;
  txn_t exp_q[$];

  logic          m_last;
  logic [DW-1:0] m_irdata, m_drdata;

  function automatic logic model_pick(input logic bi, input logic bd);
    if (bi && bd) begin
`ifdef MEM_ARB_RR_EN
      return ~m_last;
`else
      return OWN_D;
`endif
    end
    return bi ? OWN_I : OWN_D;
  endfunction

  task automatic model_push(input logic own, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
    txn_t t;
    t.own = own; t.we = we; t.addr = addr; t.wdata = wdata;
    if (own == OWN_I) begin
      m_irdata = ref_mem[addr];
      t.rdata  = m_irdata;
    end else if (we) begin
      ref_mem[addr] = wdata;
      t.rdata       = m_drdata;
    end else begin
      m_drdata = ref_mem[addr];
      t.rdata  = m_drdata;
    end
    m_last = own;
    exp_q.push_back(t);
  endtask

  task automatic model_reset();
    m_last   = OWN_D;
    m_irdata = '0;
    m_drdata = '0;
    exp_q.delete();
  endtask

  // Monitor: checks each transaction at strobe start and at its ack.
  int   strobe_cnt  = 0;
  logic prev_strobe = 1'b0;
  txn_t cur;
  always @(negedge clk) begin
    if (!reset) begin
      strobe_cnt  = 0;
      prev_strobe = 1'b0;
    end else begin
      if (mem_oe && mem_w) begin
        errors++;
        $display("FAIL strobe_excl: mem_oe=1 mem_w=1 expected at most one at %0t", $time);
      end
      if ((mem_oe || mem_w) && !prev_strobe) begin
        strobe_cnt = 1;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_txn: strobe at addr %0h expected none at %0t", mem_addr, $time);
        end else begin
          cur = exp_q[0];
          check("owner", owner, cur.own);
          check("mem_addr", mem_addr, cur.addr);
          check("strobe_kind", {mem_oe, mem_w}, {~cur.we, cur.we});
          check("busy_access", busy, 1'b1);
          if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        end
      end else if (mem_oe || mem_w) begin
        strobe_cnt++;
      end
      if (i_ack || d_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b expected none at %0t", i_ack, d_ack, $time);
        end else begin
          cur = exp_q.pop_front();
          check("ack_port", {i_ack, d_ack}, cur.own ? 2'b01 : 2'b10);
          check("strobe_width", strobe_cnt, WS + 1);
          check("ack_after_strobe", {prev_strobe, mem_oe | mem_w}, 2'b10);
          check("rdata", cur.own ? d_rdata : i_rdata, cur.rdata);
        end
      end
      prev_strobe = mem_oe | mem_w;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold requests until each port reaches its ack target or the total is met.
  task automatic run(input int ti, input int td, input int tot, output int cyc);
    int ni = 0;
    int nd = 0;
    cyc = 0;
    while ((ni + nd) < tot && cyc < 100 * tot + 50) begin
      tick();
      cyc++;
      if (i_ack) begin ni++; if (ni >= ti) i_req = 1'b0; end
      if (d_ack) begin nd++; if (nd >= td) d_req = 1'b0; end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check("ack_count", ni + nd, tot);
  endtask

  initial begin
    int cyc, acks, gap, oe_w;
    logic ri, rd, o;
    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    z_i_req = 1'b0; z_i_addr = 8'h33;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = DW'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[8'h10] = 16'hBEEF;
    ref_mem[8'h10] = 16'hBEEF;
    model_reset();
    repeat (2) tick();
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    check("rst_ctrl", {mem_oe, mem_w, i_ack, d_ack, busy, owner}, 0);
    reset = 1'b1;
    tick();

    // Single fetch with latency measurement.
    i_addr = 8'h10; i_req = 1'b1;
    model_push(OWN_I, 1'b0, 8'h10, '0);
    run(1, 0, 1, cyc);
    check("fetch_latency", cyc, WS + 2);
    check("fetch_data", i_rdata, 16'hBEEF);

    // Data write leaves d_rdata alone.
    d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'h1234; d_req = 1'b1;
    model_push(OWN_D, 1'b1, 8'h20, 16'h1234);
    run(0, 1, 1, cyc);
    check("write_keeps_drdata", d_rdata, 16'h0000);
    tick();
    check("mem_written", mem_arr[8'h20], 16'h1234);

    // Both requests held for four transactions.
    i_addr = 8'h50; d_addr = 8'h60; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      o = model_pick(1'b1, 1'b1);
      model_push(o, 1'b0, o ? 8'h60 : 8'h50, '0);
    end
    run(1000, 1000, 4, cyc);
    repeat (6) tick();
    check("queue_drained", exp_q.size(), 0);

    // Data request dropped one cycle after grant still completes once.
    d_we = 1'b0; d_addr = 8'h40; d_req = 1'b1;
    model_push(OWN_D, 1'b0, 8'h40, '0);
    tick();
    tick();
    d_req = 1'b0;
    run(0, 1, 1, cyc);
    repeat (8) tick();
    check("drop_idle_busy", busy, 1'b0);
    check("drop_queue", exp_q.size(), 0);

    // Randomised rounds.
    for (int r = 0; r < 30; r++) begin
      ri = 1'($urandom); rd = 1'($urandom);
      if (!ri && !rd) ri = 1'b1;
      i_addr = AW'($urandom); d_addr = AW'($urandom);
      d_we = 1'($urandom); d_wdata = DW'($urandom);
      if (ri && rd) begin
        o = model_pick(1'b1, 1'b1);
        model_push(o, o ? d_we : 1'b0, o ? d_addr : i_addr, d_wdata);
        model_push(~o, ~o ? d_we : 1'b0, ~o ? d_addr : i_addr, d_wdata);
      end else begin
        model_push(rd, rd ? d_we : 1'b0, rd ? d_addr : i_addr, d_wdata);
      end
      i_req = ri; d_req = rd;
      run(int'(ri), int'(rd), int'(ri) + int'(rd), cyc);
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (4) tick();
    check("random_drained", exp_q.size(), 0);

    // Reset during the ACCESS of a data read aborts it.
    d_we = 1'b0; d_addr = 8'h30; d_req = 1'b1;
    model_push(OWN_D, 1'b0, 8'h30, '0);
    cyc = 0;
    while (!mem_oe && cyc < 20) begin tick(); cyc++; end
    check("abort_saw_oe", mem_oe, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort_outputs", {mem_oe, mem_w, busy, i_ack, d_ack}, 0);
    d_req = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    repeat (6) tick();
    check("abort_idle", {busy, mem_oe, mem_w}, 0);
    check("abort_rdata", {i_rdata, d_rdata}, 0);

    // WAIT_STATES=0 instance: continuous fetch.
    z_i_req = 1'b1;
    acks = 0; gap = 0; oe_w = 0; cyc = 0;
    while (acks < 5 && cyc < 60) begin
      tick(); cyc++; gap++;
      if (z_mem_oe) oe_w++;
      if (z_i_ack) begin
        if (acks > 0) check("ws0_period", gap, 3);
        check("ws0_oe_width", oe_w, 1);
        check("ws0_rdata", z_i_rdata, 16'hC333);
        acks++; gap = 0; oe_w = 0;
      end
    end
    z_i_req = 1'b0;
    check("ws0_acks", acks, 5);

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous memory port between two requesters: the instruction-fetch path (read-only) and the data load/store path.
- Sits between the control unit / MARs and the external memory strobes. Replaces separate I_MEM/D_MEM strobe generation with one sequenced port.
- Handles winner selection, wait-state timing, read-data capture and a one-cycle ack per transaction.

Parameters:
- ADDR_W, 8, address width of both requesters and the memory port
- DATA_W, 16, data word width
- WAIT_STATES, 1, extra cycles the strobe is held before read data is sampled; legal range 0..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  instruction fetch request, level
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  registered fetch data
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
- d_req  in  1  data access request, level
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  registered load data
- d_ack  out  1  one-cycle pulse: data access complete
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_oe  out  1  memory read strobe
- mem_w  out  1  memory write strobe
- busy  out  1  high in ACCESS and DONE
- owner  out  1  0 = instruction, 1 = data; valid while busy

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: mem_addr, mem_wdata, i_rdata, d_rdata, strobes, acks, busy, owner.
  - last_grant is set to data, so the first tie goes to the instruction port.
  - Reset mid-transaction aborts it immediately. No ack is issued and strobes drop in the same cycle.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If i_req or d_req is high, pick the winner and latch address, d_we and d_wdata into mem_addr / mem_wdata.
  - Set owner and load wait counter = WAIT_STATES, then go to ACCESS.
  - Otherwise stay in IDLE. mem_addr holds its last value; strobes stay 0.
- ACCESS:
  - mem_oe=1 for a read, or mem_w=1 for a data write. Address and wdata are stable for the whole state.
  - The counter decrements each cycle. When it reaches 0:
    - a read captures mem_rdata into i_rdata or d_rdata per owner;
    - the FSM goes to DONE.
  - Strobe width is WAIT_STATES+1 cycles.
- DONE:
  - Strobes are 0. The owner's ack is 1 for exactly one cycle.
  - last_grant is updated to owner. The FSM returns to IDLE.
- Latency:
  - A request first sampled in IDLE at cycle N gives its ack at cycle N+WAIT_STATES+2.
  - Minimum back-to-back period is WAIT_STATES+3 cycles.
- Handshake rules:
  - A requester holds req and its address/data until its ack.
  - A req still high in the cycle after ack is treated as a new request.
  - If req drops mid-transaction, the transaction still completes and ack still pulses.
  - Input changes outside IDLE are ignored.
- rdata hold: i_rdata and d_rdata hold until the next read completion for that port. A data write leaves d_rdata unchanged.
- WAIT_STATES=0: ACCESS lasts one cycle.
- Only one strobe is active at any time. mem_oe and mem_w are never both 1.

Optional Feature:
- Macro: MEM_ARB_RR_EN
- Defined: round-robin arbitration.
  - On simultaneous requests the port that is not last_grant wins.
  - A single request always wins.
- Undefined: fixed priority, data over instruction. last_grant is still maintained but unused.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - owner constants OWN_I=1'b0, OWN_D=1'b1;
  - width of the wait counter (4 bits).
- Sub-module mem_arb_pick: combinational winner selection from i_req, d_req and last_grant, with the MEM_ARB_RR_EN variant inside it.
- The FSM, counter and datapath registers stay in the top.

Test Plan:
- Reset, then i_req=1, i_addr=8'h10, memory returns 16'hBEEF (WAIT_STATES=1) -> mem_oe high for 2 cycles, i_ack one cycle at N+3, i_rdata=16'hBEEF, d_ack never asserts.
- d_req=1, d_we=1, d_addr=8'h20, d_wdata=16'h1234 -> mem_w high for 2 cycles with mem_addr=8'h20 and mem_wdata=16'h1234, mem_oe stays 0, d_ack pulses, d_rdata unchanged.
- i_req and d_req both held high for 4 transactions -> fixed priority gives owner D,D,D,D. With MEM_ARB_RR_EN, first owner is I, then D,I,D.
- Reset asserted during ACCESS of a data read -> strobes, busy and acks go to 0 immediately. After release, IDLE, with no ack for the aborted access.
- WAIT_STATES=0, continuous i_req -> ack every 3 cycles, mem_oe one cycle wide per access.
- d_req dropped one cycle after grant -> the access still completes, d_ack pulses once, and no new transaction starts.
